seq_divider32: RTL and testbench

Multicycle restoring divider for the calculator datapath. Produces quotient and remainder for the divide operation. Sits directly upstream of the 32-bit OR-reduction zero-detect: the remainder output feeds that reducer to form the "inexact result" status flag. One division runs at a time under a start/busy/done handshake.

---
 rtl/seq_divider32.sv | 167 ++++++++++++++++
 tb/tb_seq_divider32.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/seq_divider32.sv
// seq_divider32: multicycle restoring divider, one quotient bit per clock,
// MSB first, with a start/busy/done handshake.
// Optional macro SIGNED_DIV_EN: two's-complement operands with an extra
// sign-fix cycle before DONE. If it is undefined the divider is purely unsigned.
// Quotient/remainder/div_by_zero are loaded only on entry to DONE. They stay
// steady between done pulses for the downstream zero-detect.
module seq_divider32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SFIX, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;     // restoring step index
  logic [WIDTH-1:0] dq_q, dq_d;       // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs_q, dvs_d;     // latched divisor (magnitude when signed)
  logic [WIDTH:0]   rem_q, rem_d;     // partial remainder, one guard bit
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             dbz_q, dbz_d;
`ifdef SIGNED_DIV_EN
  logic             negq_q, negq_d;   // quotient must be negated
  logic             negr_q, negr_d;   // remainder must be negated (dividend sign)
`endif

  // Restoring step datapath
  logic [WIDTH:0]   shifted, diff, rem_step;
  logic [WIDTH-1:0] dq_step;
  logic             fits;

  always_comb begin
    shifted  = {rem_q[WIDTH-1:0], dq_q[WIDTH-1]};
    diff     = shifted - {1'b0, dvs_q};
    fits     = ~diff[WIDTH];
    rem_step = fits ? diff : shifted;
    dq_step  = {dq_q[WIDTH-2:0], fits};
  end

  // Next-state, datapath update and handshake outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dq_d    = dq_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    res_d   = res_q;
    dbz_d   = dbz_q;
`ifdef SIGNED_DIV_EN
    negq_d  = negq_q;
    negr_d  = negr_q;
`endif
    busy_o  = 1'b0;
    done_o  = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        done_o  = (state_q == S_DONE);
        state_d = S_IDLE;
        if (start_i) begin
          cnt_d = '0;
          rem_d = '0;
`ifdef SIGNED_DIV_EN
          dq_d   = dividend_i[WIDTH-1] ? (~dividend_i + 1'b1) : dividend_i;
          dvs_d  = divisor_i[WIDTH-1]  ? (~divisor_i + 1'b1)  : divisor_i;
          negq_d = dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
          negr_d = dividend_i[WIDTH-1];
`else
          dq_d  = dividend_i;
          dvs_d = divisor_i;
`endif
          if (divisor_i == '0) begin
            // No iterations: results are defined directly
            state_d = S_DONE;
            quo_d   = '1;
            res_d   = dividend_i;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        busy_o = 1'b1;
        rem_d  = rem_step;
        dq_d   = dq_step;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) begin
`ifdef SIGNED_DIV_EN
          state_d = S_SFIX;
`else
          state_d = S_DONE;
          quo_d   = dq_step;
          res_d   = rem_step[WIDTH-1:0];
          dbz_d   = 1'b0;
`endif
        end
      end
      S_SFIX: begin
        // Reapply signs: quotient truncates toward zero, remainder follows dividend
        busy_o  = 1'b1;
        state_d = S_DONE;
        dbz_d   = 1'b0;
`ifdef SIGNED_DIV_EN
        quo_d   = negq_q ? (~dq_q + 1'b1) : dq_q;
        res_d   = negr_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
`else
        quo_d   = dq_q;
        res_d   = rem_q[WIDTH-1:0];
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Datapath and result registers; reset aborts any division in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      dq_q   <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      res_q  <= '0;
      dbz_q  <= 1'b0;
`ifdef SIGNED_DIV_EN
      negq_q <= 1'b0;
      negr_q <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      dq_q   <= dq_d;
      dvs_q  <= dvs_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      res_q  <= res_d;
      dbz_q  <= dbz_d;
`ifdef SIGNED_DIV_EN
      negq_q <= negq_d;
      negr_q <= negr_d;
`endif
    end
  end

  assign quotient_o    = quo_q;
  assign remainder_o   = res_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_seq_divider32.sv
// Directed bench for seq_divider32 with a scoreboard of expected results.
module tb_seq_divider32;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic        busy_o, done_o, div_by_zero_o;
  logic [31:0] quotient_o, remainder_o;

  seq_divider32 #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i),
    .busy_o(busy_o), .done_o(done_o),
    .quotient_o(quotient_o), .remainder_o(remainder_o),
    .div_by_zero_o(div_by_zero_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_q = '0, last_r = '0;
  logic        last_dbz = 1'b0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.dbz = 1'b1; e.lat = 1;
    end else begin
      e.dbz = 1'b0;
`ifdef SIGNED_DIV_EN
      e.lat = 34;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.q = 32'h8000_0000; e.r = 32'd0;
      end else begin
        e.q = $signed(a) / $signed(b);
        e.r = $signed(a) % $signed(b);
      end
`else
      e.lat = 33;
      e.q = a / b;
      e.r = a % b;
`endif
    end
    return e;
  endfunction

  // Drive a one-cycle start; the edge it is sampled on counts as edge 1
  task automatic do_start(input logic [31:0] a, input logic [31:0] b, input bit expect_accept);
    if (expect_accept) sb.push_back(model(a, b));
    start_i = 1'b1; dividend_i = a; divisor_i = b;
    tick;
    start_i = 1'b0;
    dividend_i = $urandom; divisor_i = $urandom;  // operands must not be re-read
  endtask

  // Wait for done (bounded); optionally inject an ignored start at edge inj
  task automatic wait_done(input string tag, input int inj);
    int   n = 1;
    int   nbusy = 0;
    exp_t e;
    while (!done_o && n < 200) begin
      if (busy_o) nbusy++;
      if (n == 5) begin
        chk({tag, ".hold_q"}, quotient_o, last_q);
        chk({tag, ".hold_r"}, remainder_o, last_r);
      end
      if (n == inj - 1) begin
        start_i = 1'b1; dividend_i = 32'd9; divisor_i = 32'd3;
      end
      tick;
      start_i = 1'b0;
      n++;
    end
    chk({tag, ".done"}, {31'd0, done_o}, 32'd1);
    chk({tag, ".busy_at_done"}, {31'd0, busy_o}, 32'd0);
    if (sb.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s.sb: observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".lat"}, n, e.lat);
      chk({tag, ".busy_cycles"}, nbusy, e.lat - 1);
      chk({tag, ".q"}, quotient_o, e.q);
      chk({tag, ".r"}, remainder_o, e.r);
      chk({tag, ".dbz"}, {31'd0, div_by_zero_o}, {31'd0, e.dbz});
      last_q = e.q; last_r = e.r; last_dbz = e.dbz;
    end
  endtask

  initial begin
    // Reset state
    tick; tick;
    chk("rst.busy", {31'd0, busy_o}, 32'd0);
    chk("rst.done", {31'd0, done_o}, 32'd0);
    chk("rst.q", quotient_o, 32'd0);
    chk("rst.r", remainder_o, 32'd0);
    chk("rst.dbz", {31'd0, div_by_zero_o}, 32'd0);
    rst = 1'b0;
    tick;

    // 100/7 with an ignored start at edge 10, then 9/3 issued in the done cycle
    do_start(32'd100, 32'd7, 1'b1);
    chk("100_7.busy_edge1", {31'd0, busy_o}, 32'd1);
    wait_done("100_7", 10);
    do_start(32'd9, 32'd3, 1'b1);
    wait_done("9_3", 0);
    tick;
    chk("idle.done_low", {31'd0, done_o}, 32'd0);
    chk("idle.q_held", quotient_o, last_q);

    do_start(32'hFFFF_FFFF, 32'd1, 1'b1);
    wait_done("max_1", 0);
    do_start(32'd3, 32'd10, 1'b1);
    wait_done("3_10", 0);

    // Divide by zero: done right after the accepting edge, busy never seen
    do_start(32'd5, 32'd0, 1'b1);
    chk("5_0.busy", {31'd0, busy_o}, 32'd0);
    wait_done("5_0", 0);
    tick;

    // Reset mid-run aborts; outputs clear immediately and no done appears
    do_start(32'd1000, 32'd3, 1'b0);
    for (int i = 1; i < 14; i++) tick;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort.q", quotient_o, 32'd0);
    chk("abort.r", remainder_o, 32'd0);
    chk("abort.dbz", {31'd0, div_by_zero_o}, 32'd0);
    chk("abort.busy", {31'd0, busy_o}, 32'd0);
    last_q = '0; last_r = '0; last_dbz = 1'b0;
    tick; tick;
    rst = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 40; i++) begin
        if (done_o) seen++;
        tick;
      end
      chk("abort.no_done", seen, 0);
    end
    do_start(32'd1000, 32'd3, 1'b1);
    wait_done("1000_3", 0);

`ifdef SIGNED_DIV_EN
    do_start(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done("m7_2", 0);
    do_start(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done("ovf", 0);
    do_start(32'd7, 32'hFFFF_FFFE, 1'b1);
    wait_done("7_m2", 0);
`endif

    // A few random operand pairs, back to back
    for (int i = 0; i < 4; i++) begin
      do_start($urandom, (i == 3) ? $urandom : ($urandom >> (8 * i)), 1'b1);
      wait_done("rand", 0);
    end

    chk("sb.empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
